operand_gather_4x32: RTL and testbench

OPERAND_GATHER_4X32 -- requirements
Module: operand_gather_4x32

---
 rtl/operand_gather_4x32.sv | 97 +++++++++
 tb/tb_operand_gather_4x32.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_gather_4x32.sv
// Operand gatherer: packs up to four accepted words into an x/y/z/w quad for a 4x32 adder stage.
// Short groups, closed early by in_last, are zero-filled.
module operand_gather_4x32 #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] y,
   output logic [DATA_W-1:0] z,
   output logic [DATA_W-1:0] w,
   output logic [2:0]        out_count,
   output logic [7:0]        out_seq
);

   // Handshakes: a word moves on a rising edge with in_valid && in_ready;
   // a quad moves on a rising edge with out_valid && out_ready.
   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

   state_t     state;
   logic [1:0] idx;
   logic       run;
   logic       accept;

   // run holds in_ready low until the first edge after reset is released
   assign in_ready  = run && !clear && ((state == FILL) || out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FILL;
         idx       <= 2'd0;
         run       <= 1'b0;
         x         <= '0;
         y         <= '0;
         z         <= '0;
         w         <= '0;
         out_count <= 3'd0;
         out_seq   <= 8'd0;
      end else begin
         run <= 1'b1;
         if (clear) begin
            state     <= FILL;
            idx       <= 2'd0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            w         <= '0;
            out_count <= 3'd0;
         end else if (state == FILL) begin
            if (accept) begin
               case (idx)
                  2'd0:    x <= in_data;
                  2'd1:    y <= in_data;
                  2'd2:    z <= in_data;
                  default: w <= in_data;
               endcase
               if (idx == 2'd3 || in_last) begin
                  state     <= HOLD;
                  idx       <= 2'd0;
                  out_count <= {1'b0, idx} + 3'd1;
               end else begin
                  idx <= idx + 2'd1;
               end
            end
         end else if (out_ready) begin
            // Retire the quad; a word arriving in the same cycle opens the next group in slot x
            out_seq   <= out_seq + 8'd1;
            state     <= FILL;
            idx       <= 2'd0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            w         <= '0;
            out_count <= 3'd0;
            if (accept) begin
               x <= in_data;
               if (in_last) begin
                  state     <= HOLD;
                  out_count <= 3'd1;
               end else begin
                  idx <= 2'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_operand_gather_4x32.sv
// Directed bench for operand_gather_4x32: a word-level model pushes expected quads,
// and a negedge monitor pops and compares them when the output handshake occurs.
module tb_operand_gather_4x32;

   localparam int QW = 4 * 32 + 3 + 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] x, y, z, w;
   logic [2:0]  out_count;
   logic [7:0]  out_seq;

   int vectors    = 0;
   int miscompares = 0;
   int cycles     = 0;

   logic [QW-1:0] exp_q[$];
   logic [31:0]   m_slots[4];
   int            m_idx;
   logic [7:0]    m_seq;

   operand_gather_4x32 #(.DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .x(x), .y(y), .z(z), .w(w), .out_count(out_count), .out_seq(out_seq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycles <= cycles + 1;

   // Scoreboard side: compare every quad that completes an output handshake
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !clear) begin
         logic [QW-1:0] got, exp;
         got = {x, y, z, w, out_count, out_seq};
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL quad_unexpected got=%h expected=none", got);
         end else begin
            exp = exp_q.pop_front();
            assert (got === exp) else begin
               miscompares++;
               $error("FAIL quad got=%h expected=%h", got, exp);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset_group();
      for (int i = 0; i < 4; i++) m_slots[i] = 32'd0;
      m_idx = 0;
   endtask

   task automatic model_accept(input logic [31:0] d, input logic last);
      m_slots[m_idx] = d;
      if (m_idx == 3 || last) begin
         exp_q.push_back({m_slots[0], m_slots[1], m_slots[2], m_slots[3], 3'(m_idx + 1), m_seq});
         m_seq = m_seq + 8'd1;
         model_reset_group();
      end else begin
         m_idx++;
      end
   endtask

   task automatic send_word(input logic [31:0] d, input logic last);
      bit ok;
      ok = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (in_ready) begin
            model_accept(d, last);
            ok = 1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("accept_timeout", 32'(ok), 32'd1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int words, c0;
      logic [31:0] hx;
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      m_seq = 8'd0;
      model_reset_group();

      // Reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_x", x, 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_seq", 32'(out_seq), 32'd0);
      step(); step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_before_edge", 32'(in_ready), 32'd0);
      step();
      @(negedge clk);
      chk("ready_after_edge", 32'(in_ready), 32'd1);
      step();

      // Scenario 1: full quad, single-cycle out_valid, seq advances
      send_word(32'd1, 1'b0); send_word(32'd2, 1'b0); send_word(32'd3, 1'b0); send_word(32'd4, 1'b0);
      @(negedge clk);
      chk("s1_valid", 32'(out_valid), 32'd1);
      step();
      @(negedge clk);
      chk("s1_valid_drop", 32'(out_valid), 32'd0);
      chk("s1_seq_next", 32'(out_seq), 32'd1);
      step();

      // Scenario 2: short group zero-filled
      send_word(32'hFFFF_FFFF, 1'b0); send_word(32'hFFFF_FFFF, 1'b1);
      step(); step();

      // Scenario 3: backpressure for 3 cycles, outputs stable, in_ready low
      out_ready = 1'b0;
      send_word(32'hA5A5_0001, 1'b0); send_word(32'h0000_0002, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("s3_valid", 32'(out_valid), 32'd1);
         chk("s3_in_ready", 32'(in_ready), 32'd0);
         chk("s3_x", x, 32'hA5A5_0001);
         chk("s3_z", z, 32'hDEAD_BEEF);
         chk("s3_w", w, 32'd0);
         chk("s3_count", 32'(out_count), 32'd3);
         step();
      end
      out_ready = 1'b1;
      step();
      @(negedge clk);
      chk("s3_retired", 32'(out_valid), 32'd0);
      step();

      // Scenario 4: retire and accept in the same cycle, no bubble
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_word(32'(100 + i), 1'b0);
      out_ready = 1'b1;
      send_word(32'd7, 1'b0);
      @(negedge clk);
      chk("s4_valid", 32'(out_valid), 32'd0);
      chk("s4_x", x, 32'd7);
      chk("s4_y", y, 32'd0);
      chk("s4_w", w, 32'd0);
      step();
      out_ready = 1'b0;
      send_word(32'd9, 1'b1);
      out_ready = 1'b1;
      send_word(32'd3, 1'b1);
      @(negedge clk);
      chk("s4_hold_last_valid", 32'(out_valid), 32'd1);
      chk("s4_hold_last_count", 32'(out_count), 32'd1);
      chk("s4_hold_last_x", x, 32'd3);
      step(); step();

      // Scenario 5: clear mid-group keeps out_seq
      hx = 32'(out_seq);
      send_word(32'd55, 1'b0); send_word(32'd66, 1'b0);
      clear = 1'b1;
      in_valid = 1'b1; in_data = 32'd77;
      @(negedge clk);
      chk("s5_ready_clear", 32'(in_ready), 32'd0);
      step();
      clear = 1'b0; in_valid = 1'b0;
      model_reset_group();
      @(negedge clk);
      chk("s5_x_cleared", x, 32'd0);
      chk("s5_seq_kept", 32'(out_seq), hx);
      step();
      for (int i = 5; i <= 8; i++) send_word(32'(i), 1'b0);
      step(); step();

      // Scenario 6a: async reset during HOLD
      out_ready = 1'b0;
      send_word(32'h1234_5678, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("s6_async_valid", 32'(out_valid), 32'd0);
      chk("s6_async_x", x, 32'd0);
      chk("s6_async_seq", 32'(out_seq), 32'd0);
      chk("s6_async_ready", 32'(in_ready), 32'd0);
      exp_q.delete();
      m_seq = 8'd0;
      model_reset_group();
      out_ready = 1'b1;
      step();
      rst_n = 1'b1;
      step(); step();

      // Scenario 6b: 256 random groups back-to-back, seq wraps, one word per cycle
      words = 0;
      c0 = cycles;
      for (int g = 0; g < 256; g++) begin
         int len;
         len = $urandom_range(1, 4);
         for (int k = 0; k < len; k++) begin
            send_word($urandom, (k == len - 1) ? 1'b1 : 1'b0);
            words++;
         end
      end
      chk("s6_throughput", 32'(cycles - c0), 32'(words));
      step();
      @(negedge clk);
      chk("s6_seq_wrap", 32'(out_seq), 32'd0);
      step(); step();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
